// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a stereo MEMS microphone pair: generates sck/ws from the audio
// clock, deserialises the shared data line and hands each stereo pair to a one-deep holding register.
module i2s_mic_rx #(
    parameter int DATA_W      = 24,
    parameter int SCK_DIV     = 1,
    parameter int WAKE_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    output logic              mic_sck,
    output logic              mic_ws,
    input  logic              mic_sd,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              running,
    output logic [1:0]        fsm_state
);

    localparam int               DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [5:0]       L_FIRST   = 6'd1;
    localparam logic [5:0]       L_LAST    = 6'(DATA_W);
    localparam logic [5:0]       R_FIRST   = 6'd33;
    localparam logic [5:0]       R_LAST    = 6'(32 + DATA_W);
    localparam logic [7:0]       WAKE_INIT = 8'(WAKE_FRAMES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic              lock_meta;
    logic              locked_s;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [7:0]        wake_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        bit_cnt;
    logic [5:0]        bit_cnt_next;
    logic [DATA_W-1:0] shift_l;
    logic [DATA_W-1:0] shift_r;
    logic              frame_done;
    logic              active;
    logic              tick;
    logic              sck_rise;
    logic              sck_fall;
    logic              in_left;
    logic              in_right;
    logic              frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    // The bit clock only runs once the FSM has left IDLE, so the first rise lands
    // SCK_DIV cycles after the IDLE exit; a lock loss freezes it immediately.
    assign active       = (state != ST_IDLE) && locked_s;
    assign tick         = active && (div_cnt == DIV_LAST);
    assign sck_rise     = tick && !mic_sck;
    assign sck_fall     = tick && mic_sck;
    assign bit_cnt_next = bit_cnt + 6'd1;
    assign in_left      = (bit_cnt >= L_FIRST) && (bit_cnt <= L_LAST);
    assign in_right     = (bit_cnt >= R_FIRST) && (bit_cnt <= R_LAST);
    assign frame_end    = sck_rise && (bit_cnt == R_LAST);
    assign fsm_state    = state;

    always_comb begin
        state_next = state;
        if (!locked_s) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = (WAKE_INIT == 8'd0) ? ST_RUN : ST_WAKE;
                ST_WAKE: if (frame_end && (wake_cnt == 8'd1)) state_next = ST_RUN;
                ST_RUN:  state_next = ST_RUN;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wake_cnt <= WAKE_INIT;
            running  <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUN);
            if (state == ST_IDLE) begin
                wake_cnt <= WAKE_INIT;
            end else if ((state == ST_WAKE) && frame_end) begin
                wake_cnt <= wake_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            mic_sck <= 1'b0;
            mic_ws  <= 1'b0;
            shift_l <= '0;
            shift_r <= '0;
        end else if (!active) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            mic_sck <= 1'b0;
            mic_ws  <= 1'b0;
            shift_l <= '0;
            shift_r <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                mic_sck <= ~mic_sck;
            end
            // Slot and word select advance together on the falling edge; the mic
            // drives its next bit there and we sample it on the following rise.
            if (sck_fall) begin
                bit_cnt <= bit_cnt_next;
                mic_ws  <= bit_cnt_next[5];
            end
            if (sck_rise && in_left) begin
                shift_l <= {shift_l[DATA_W-2:0], mic_sd};
            end
            if (sck_rise && in_right) begin
                shift_r <= {shift_r[DATA_W-2:0], mic_sd};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end && (state == ST_RUN);
        end
    end

    // Handshake: sample_valid marks a full holding register; a pair transfers on any
    // clk edge where sample_valid & sample_ready, and the pair is stable while valid waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!sample_valid || sample_ready) begin
                    sample_l     <= shift_l;
                    sample_r     <= shift_r;
                    sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule
